memctl_dp: RTL and testbench
============================

# memctl_dp

Parametrised dual-port memory controller: the successor to the single-cycle 16-bit data/instruction memory.
- Instruction port: registered halfword fetch every request.
- Data port: byte or halfword access through a real read-modify-write FSM, so byte writes merge with freshly read data.
- MMIO decode: `MMIO_N` request/done channels with an optional timeout.
- Placement: between the core's fetch/LSU stages and the RAM and peripherals (LED, UART, LCD).

## Interface
Parameters:
- `ADDR_W`, 16, byte address width of both ports.
- `RAM_BYTES`, 32768, RAM size (even, power of two). RAM region is `addr < RAM_BYTES`.
- `MMIO_BASE`, 16'hF000, first MMIO byte address.
- `MMIO_N`, 3, number of MMIO channels. Channel index is `(addr - MMIO_BASE) >> MMIO_SHIFT`.
- `MMIO_SHIFT`, 4, log2 of bytes per MMIO channel window.
- `TIMEOUT_CYCLES`, 1024, MMIO wait limit; used only with the timeout macro.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `data_addr` in `ADDR_W`: data byte address.
- `data_wdata` in 16: write data; byte writes use `[7:0]`.
- `data_size` in 1: 0 = byte, 1 = halfword.
- `data_write` in 1: 1 = write, 0 = read.
- `data_req` in 1: access request (level).
- `data_rdata` out 16: read data, zero-extended for byte reads; valid while `data_done` is high.
- `data_done` out 1: one-cycle completion pulse.
- `data_err` out 1: error flag, valid with `data_done`.
- `inst_addr` in `ADDR_W`: fetch address; bit 0 ignored.
- `inst_req` in 1: fetch request.
- `inst_out` out 16: fetched halfword.
- `inst_done` out 1: one-cycle fetch pulse.
- `mmio_req` out `MMIO_N`: one-hot, held until the matching done.
- `mmio_addr` out `ADDR_W`, `mmio_wdata` out 8, `mmio_write` out 1: latched copies, stable while `mmio_req` is nonzero.
- `mmio_rdata` in `8*MMIO_N`: per-channel read data, sampled with done.
- `mmio_done` in `MMIO_N`: per-channel completion.

## Operation
Data FSM states: `IDLE`, `ACCESS`, `MMIO_WAIT`, `RESP`.
- **IDLE:** `data_req` is sampled only here. The block latches addr, wdata, size and write, then decodes:
  - RAM → `ACCESS`; the port-A read is issued in the same cycle.
  - MMIO, valid channel → `MMIO_WAIT`; `mmio_req[ch]` rises next cycle.
  - Unmapped address, or MMIO channel ≥ `MMIO_N` → `RESP` with err=1.
  - Halfword access with `addr[0]=1` → `RESP` with err=1; no write, no MMIO request.
  - Halfword access to MMIO → err=1.
- **ACCESS:** RAM word is available.
  - Read: select the byte (`addr[0]` picks `[7:0]` or `[15:8]`) or the whole halfword into `data_rdata`.
  - Write: drive port A with the merged word (byte lane replaced, other lane from the read data); write-enable for exactly this cycle.
  - Next state → `RESP`.
- **MMIO_WAIT:** hold `mmio_req[ch]` until `mmio_done[ch]`. Then capture `mmio_rdata[8*ch+:8]` zero-extended, drop `mmio_req` on the next edge, → `RESP`. Done bits of other channels are ignored.
- **RESP:** `data_done`=1 for one cycle → `IDLE`.
- **Back-to-back:** if `data_req` is still high in the cycle after done, a new access starts. The requester deasserts `data_req` or presents the next request in the done cycle.

Instruction port:
- Independent; no stall.
- `inst_req` at edge N → `inst_out` and `inst_done` valid in cycle N+1.
- Accepts a new request every cycle.
- Addresses ≥ `RAM_BYTES` return 16'h0000.

Collision: an inst read of the word being written in `ACCESS` returns the old contents (read-before-write).

## Timing
- **Reset values:** all outputs 0, state `IDLE`, timeout counter 0. RAM contents are preserved. Reset mid-access aborts it: no `data_done`, `mmio_req` cleared asynchronously.
- **RAM read/write latency:** req accepted at edge N; `data_done` high in cycle N+2.
- **Error latency:** `data_done` high in cycle N+1.
- **MMIO latency:** `mmio_req` high from cycle N+1. `mmio_done` seen at edge M → `data_done` in cycle M+1.
- **Inst latency:** 1 cycle, fully pipelined.

## Configuration
- Macro: `MEMCTL_MMIO_TIMEOUT_EN`.
- **Defined:**
  - An `$clog2(TIMEOUT_CYCLES+1)`-bit counter runs in `MMIO_WAIT`; it clears on entry.
  - At count == `TIMEOUT_CYCLES` without done: drop `mmio_req`, → `RESP` with err=1 and rdata=0.
  - A done on the same cycle as expiry wins; err=0.
- **Undefined:** `MMIO_WAIT` waits indefinitely. No counter logic, and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `memctl_pkg`:
  - `state_t` enum (`IDLE`, `ACCESS`, `MMIO_WAIT`, `RESP`);
  - `size_t` (`SIZE_BYTE`, `SIZE_HALF`);
  - default MMIO base constants for LED/UART/LCD.
- Sub-module `memctl_dpram`: inferred true dual-port RAM of `RAM_BYTES/2` × 16.
  - Port A read/write, port B read-only.
  - Both ports have registered outputs with read-before-write behaviour.
  - No vendor primitive.

## Test plan
- **Byte RMW:** write halfword 0x1234 to 0x0010, then byte 0xAB to 0x0011, then halfword read of 0x0010 → 0xAB34, err=0. Each done arrives 2 cycles after req.
- **Misaligned:** halfword write to 0x0011 → done in N+1, err=1. A following read of 0x0010 still returns 0xAB34.
- **MMIO handshake:** byte read at `MMIO_BASE+0x10` (ch1). Bench asserts `mmio_done[1]` after 5 cycles with rdata 0x5A → `mmio_req`=3'b010 until then, `data_rdata`=0x005A, err=0.
- **Inst collision:** in one cycle, fetch 0x0010 while the data port is in `ACCESS` writing byte 0xCD to 0x0010 → `inst_out`=0xAB34. A fetch on the next cycle → 0xABCD.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8):** MMIO ch0 access with no done → done at cycle 10, err=1, rdata=0, `mmio_req` low. Macro off: still waiting at cycle 100.
- **Reset mid-operation:** assert reset during `MMIO_WAIT` → `mmio_req`=0 and `data_done`=0 immediately. After release, a RAM read of 0x0010 returns the preserved value 0xABCD.

Source files
------------

// File: rtl/memctl_pkg.sv
// memctl_pkg: shared types and constants for the dual-port memory controller.
//   state_t : data-port FSM states
//   size_t  : data access width
//   *_BASE  : default MMIO window bases for the LED, UART and LCD peripherals
package memctl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        MMIO_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_HALF = 1'b1
    } size_t;

    localparam logic [15:0] MMIO_LED_BASE  = 16'hF000;
    localparam logic [15:0] MMIO_UART_BASE = 16'hF010;
    localparam logic [15:0] MMIO_LCD_BASE  = 16'hF020;

endpackage

// File: rtl/memctl_dp_dpram.sv
// memctl_dpram: inferred true dual-port RAM, DEPTH x DW.
//   clock            : rising-edge clock
//   a_addr/a_we/a_wdata/a_rdata : port A, read/write, registered read-before-write
//   b_en/b_addr/b_rdata         : port B, read-only, registered
// Contents are deliberately not reset so they survive a controller reset.
module memctl_dpram #(
    parameter int DEPTH = 16384,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Reads sample the array before the write lands, so a same-edge read of
    // the written word on either port returns the old contents.
    always_ff @(posedge clock) begin
        if (a_we)
            mem[a_addr] <= a_wdata;
        a_rdata <= mem[a_addr];
        if (b_en)
            b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/memctl_dp.sv
// memctl_dp: dual-port memory controller (instruction fetch + data RMW + MMIO).
//   clock, reset                       : rising-edge clock, async active-high reset
//   data_addr/wdata/size/write/req     : data request (req is a level, sampled in IDLE)
//   data_rdata/done/err                : data response, valid while data_done is high
//   inst_addr/inst_req                 : fetch request, one per cycle
//   inst_out/inst_done                 : fetch response one cycle later
//   mmio_req/addr/wdata/write          : one-hot MMIO request and latched fields
//   mmio_rdata/mmio_done               : per-channel MMIO response
// Optional feature macro: MEMCTL_MMIO_TIMEOUT_EN bounds the MMIO wait to
// TIMEOUT_CYCLES and then completes with err=1.
module memctl_dp
    import memctl_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int RAM_BYTES      = 32768,
    parameter int MMIO_BASE      = 'hF000,
    parameter int MMIO_N         = 3,
    parameter int MMIO_SHIFT     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [15:0]         data_wdata,
    input  logic                data_size,
    input  logic                data_write,
    input  logic                data_req,
    output logic [15:0]         data_rdata,
    output logic                data_done,
    output logic                data_err,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_req,
    output logic [15:0]         inst_out,
    output logic                inst_done,
    output logic [MMIO_N-1:0]   mmio_req,
    output logic [ADDR_W-1:0]   mmio_addr,
    output logic [7:0]          mmio_wdata,
    output logic                mmio_write,
    input  logic [8*MMIO_N-1:0] mmio_rdata,
    input  logic [MMIO_N-1:0]   mmio_done
);

    localparam int                AW          = $clog2(RAM_BYTES / 2);
    localparam int                CH_W        = (MMIO_N > 1) ? $clog2(MMIO_N) : 1;
    localparam logic [ADDR_W:0]   RAM_LIM     = (ADDR_W+1)'(RAM_BYTES);
    localparam logic [ADDR_W-1:0] MMIO_BASE_A = ADDR_W'(MMIO_BASE);
    localparam logic [ADDR_W-1:0] MMIO_N_A    = ADDR_W'(MMIO_N);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wdata_q;
    size_t               size_q;
    logic                write_q;
    logic [CH_W-1:0]     ch_q;
    logic [15:0]         rdata_q;
    logic                err_q;
    logic [MMIO_N-1:0]   mmio_req_q;
    logic                inst_vld_q, inst_oob_q;

    logic [AW-1:0]       a_addr;
    logic                a_we;
    logic [15:0]         a_wdata, a_rdata, b_rdata, ram_rd;
    logic                in_ram, in_mmio, misalign, acc_err, done_sel, expired;
    logic [ADDR_W-1:0]   mmio_off, ch_idx;

    // ---- request decode (only meaningful in IDLE) ----
    always_comb begin
        mmio_off = data_addr - MMIO_BASE_A;
        ch_idx   = mmio_off >> MMIO_SHIFT;
        in_ram   = {1'b0, data_addr} < RAM_LIM;
        in_mmio  = (data_addr >= MMIO_BASE_A) && (ch_idx < MMIO_N_A);
        misalign = data_size && data_addr[0];
        // MMIO is byte-only; a halfword there is an error like an unmapped hit.
        acc_err  = misalign || !(in_ram || (in_mmio && !data_size));
    end

    assign done_sel = mmio_done[ch_q];

`ifdef MEMCTL_MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    logic unused_ok;
    assign unused_ok = inst_addr[0];
`else
    assign expired = 1'b0;
    logic unused_ok;
    assign unused_ok = inst_addr[0] ^ (TIMEOUT_CYCLES != 0);
`endif

    // ---- FSM: state register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (data_req)
                           state_nx = acc_err ? RESP : (in_ram ? ACCESS : MMIO_WAIT);
            ACCESS:    state_nx = RESP;
            MMIO_WAIT: if (done_sel || expired) state_nx = RESP;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // ---- FSM: outputs / RAM port A control ----
    always_comb begin
        // In IDLE the read goes out straight from the request so the word is
        // ready in ACCESS; afterwards the latched address is used.
        a_addr    = (state == IDLE) ? data_addr[AW:1] : addr_q[AW:1];
        a_we      = (state == ACCESS) && write_q;
        a_wdata   = wdata_q;
        if (size_q == SIZE_BYTE)
            a_wdata = addr_q[0] ? {wdata_q[7:0], a_rdata[7:0]} : {a_rdata[15:8], wdata_q[7:0]};
        ram_rd    = a_rdata;
        if (size_q == SIZE_BYTE)
            ram_rd = {8'h00, addr_q[0] ? a_rdata[15:8] : a_rdata[7:0]};
        data_done = (state == RESP);
    end

    // ---- data-path registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            write_q    <= 1'b0;
            ch_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mmio_req_q <= '0;
`ifdef MEMCTL_MMIO_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (data_req) begin
                    addr_q  <= data_addr;
                    wdata_q <= data_wdata;
                    size_q  <= size_t'(data_size);
                    write_q <= data_write;
                    ch_q    <= ch_idx[CH_W-1:0];
                    rdata_q <= '0;
                    err_q   <= acc_err;
                    if (!acc_err && !in_ram)
                        mmio_req_q <= MMIO_N'(1) << ch_idx[CH_W-1:0];
`ifdef MEMCTL_MMIO_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                ACCESS: begin
                    rdata_q <= write_q ? 16'h0000 : ram_rd;
                    err_q   <= 1'b0;
                end
                MMIO_WAIT: begin
                    // A done arriving on the expiry cycle takes priority.
                    if (done_sel) begin
                        rdata_q    <= {8'h00, mmio_rdata[8*ch_q +: 8]};
                        err_q      <= 1'b0;
                        mmio_req_q <= '0;
                    end else if (expired) begin
                        rdata_q    <= '0;
                        err_q      <= 1'b1;
                        mmio_req_q <= '0;
                    end
`ifdef MEMCTL_MMIO_TIMEOUT_EN
                    else cnt_q <= cnt_q + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // ---- instruction port ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_vld_q <= 1'b0;
            inst_oob_q <= 1'b0;
        end else begin
            inst_vld_q <= inst_req;
            inst_oob_q <= {1'b0, inst_addr} >= RAM_LIM;
        end
    end

    // Gating by the valid bit keeps inst_out at zero through reset even though
    // the RAM output register itself is not reset.
    assign inst_out  = (inst_vld_q && !inst_oob_q) ? b_rdata : 16'h0000;
    assign inst_done = inst_vld_q;

    assign data_rdata = rdata_q;
    assign data_err   = err_q;
    assign mmio_req   = mmio_req_q;
    assign mmio_addr  = addr_q;
    assign mmio_wdata = wdata_q[7:0];
    assign mmio_write = write_q;

    memctl_dpram #(.DEPTH(RAM_BYTES / 2), .DW(16), .AW(AW)) u_ram (
        .clock   (clock),
        .a_addr  (a_addr),
        .a_we    (a_we),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_en    (inst_req),
        .b_addr  (inst_addr[AW:1]),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_memctl_dp.sv
// tb_memctl_dp: directed self-checking bench for memctl_dp.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_memctl_dp;
    logic        clock, reset;
    logic [15:0] data_addr, data_wdata, data_rdata;
    logic        data_size, data_write, data_req, data_done, data_err;
    logic [15:0] inst_addr, inst_out;
    logic        inst_req, inst_done;
    logic [2:0]  mmio_req, mmio_done;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_wdata;
    logic        mmio_write;
    logic [23:0] mmio_rdata;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] rd;
    logic        er;
    int          lat;
    logic        seen;

    memctl_dp #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_size(data_size),
        .data_write(data_write), .data_req(data_req), .data_rdata(data_rdata),
        .data_done(data_done), .data_err(data_err),
        .inst_addr(inst_addr), .inst_req(inst_req), .inst_out(inst_out), .inst_done(inst_done),
        .mmio_req(mmio_req), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_write(mmio_write), .mmio_rdata(mmio_rdata), .mmio_done(mmio_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One data access; lat = cycles from the accepting edge to the done cycle
    // (0 when no done appears within the budget).
    task automatic do_acc(input logic [15:0] a, input logic [15:0] wd, input logic sz,
                          input logic wr, output logic [15:0] r, output logic e, output int l);
        @(negedge clock);
        data_addr = a; data_wdata = wd; data_size = sz; data_write = wr; data_req = 1'b1;
        @(posedge clock);
        l = 0; r = '0; e = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (data_done) begin
                l = k; r = data_rdata; e = data_err;
                break;
            end
        end
        data_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        data_addr = '0; data_wdata = '0; data_size = 1'b0; data_write = 1'b0; data_req = 1'b0;
        inst_addr = '0; inst_req = 1'b0; mmio_rdata = '0; mmio_done = '0;
        repeat (2) @(negedge clock);
        check("rst_done",   data_done,  0);
        check("rst_err",    data_err,   0);
        check("rst_rdata",  data_rdata, 0);
        check("rst_idone",  inst_done,  0);
        check("rst_iout",   inst_out,   0);
        check("rst_mreq",   mmio_req,   0);
        check("rst_mwrite", mmio_write, 0);
        reset = 1'b0;

        // byte read-modify-write
        do_acc(16'h0010, 16'h1234, 1'b1, 1'b1, rd, er, lat);
        check("wr_half_lat", lat, 2);
        check("wr_half_err", er, 0);
        do_acc(16'h0011, 16'h00AB, 1'b0, 1'b1, rd, er, lat);
        check("wr_byte_lat", lat, 2);
        do_acc(16'h0010, 16'h0000, 1'b1, 1'b0, rd, er, lat);
        check("rd_half_data", rd, 16'hAB34);
        check("rd_half_err", er, 0);
        check("rd_half_lat", lat, 2);
        do_acc(16'h0011, 16'h0000, 1'b0, 1'b0, rd, er, lat);
        check("rd_byte_hi", rd, 16'h00AB);
        do_acc(16'h0010, 16'h0000, 1'b0, 1'b0, rd, er, lat);
        check("rd_byte_lo", rd, 16'h0034);

        // misaligned halfword write must not touch RAM
        do_acc(16'h0011, 16'hFFFF, 1'b1, 1'b1, rd, er, lat);
        check("misal_err", er, 1);
        check("misal_lat", lat, 1);
        do_acc(16'h0010, 16'h0000, 1'b1, 1'b0, rd, er, lat);
        check("misal_keep", rd, 16'hAB34);

        // decode errors
        do_acc(16'h9000, 16'h0000, 1'b0, 1'b0, rd, er, lat);
        check("unmap_err", er, 1);
        check("unmap_lat", lat, 1);
        do_acc(16'hF000, 16'h0000, 1'b1, 1'b0, rd, er, lat);
        check("mmio_half_err", er, 1);
        check("mmio_half_lat", lat, 1);
        do_acc(16'hF030, 16'h0000, 1'b0, 1'b0, rd, er, lat);
        check("mmio_ch3_err", er, 1);
        check("mmio_ch3_mreq", mmio_req, 0);

        // MMIO read handshake on channel 1
        @(negedge clock);
        data_addr = 16'hF010; data_size = 1'b0; data_write = 1'b0; data_req = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check("mmio_rd_req", mmio_req, 3'b010);
            check("mmio_rd_wait", data_done, 0);
        end
        check("mmio_rd_addr", mmio_addr, 16'hF010);
        mmio_rdata = 24'h115A22; mmio_done = 3'b010;
        @(negedge clock);
        check("mmio_rd_done", data_done, 1);
        check("mmio_rd_data", data_rdata, 16'h005A);
        check("mmio_rd_err", data_err, 0);
        check("mmio_rd_drop", mmio_req, 0);
        data_req = 1'b0; mmio_done = '0;

        // MMIO write on channel 2; a done on another channel is ignored
        @(negedge clock);
        data_addr = 16'hF020; data_wdata = 16'h0077; data_write = 1'b1; data_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mmio_wr_req", mmio_req, 3'b100);
        check("mmio_wr_we", mmio_write, 1);
        check("mmio_wr_data", mmio_wdata, 8'h77);
        mmio_done = 3'b001;
        @(negedge clock);
        check("mmio_wr_other", data_done, 0);
        check("mmio_wr_hold", mmio_req, 3'b100);
        mmio_done = 3'b100;
        @(negedge clock);
        check("mmio_wr_done", data_done, 1);
        check("mmio_wr_err", data_err, 0);
        data_req = 1'b0; mmio_done = '0; data_write = 1'b0;

        // instruction fetch colliding with a byte write in ACCESS
        @(negedge clock);
        data_addr = 16'h0010; data_wdata = 16'h00CD; data_size = 1'b0; data_write = 1'b1; data_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inst_req = 1'b1; inst_addr = 16'h0010;
        @(negedge clock);
        check("coll_data_done", data_done, 1);
        check("coll_idone", inst_done, 1);
        check("coll_old", inst_out, 16'hAB34);
        data_req = 1'b0; data_write = 1'b0;
        @(negedge clock);
        check("coll_new", inst_out, 16'hABCD);
        inst_req = 1'b0;
        @(negedge clock);
        check("inst_idle", inst_done, 0);

        // out-of-range fetch returns zero; bit 0 of the fetch address is ignored
        do_acc(16'h0000, 16'hBEEF, 1'b1, 1'b1, rd, er, lat);
        @(negedge clock);
        inst_req = 1'b1; inst_addr = 16'h8000;
        @(negedge clock);
        check("inst_oob", inst_out, 16'h0000);
        inst_addr = 16'h0001;
        @(negedge clock);
        check("inst_w0", inst_out, 16'hBEEF);
        inst_req = 1'b0;

`ifdef MEMCTL_MMIO_TIMEOUT_EN
        do_acc(16'hF000, 16'h0000, 1'b0, 1'b0, rd, er, lat);
        check("to_lat", lat, 10);
        check("to_err", er, 1);
        check("to_rdata", rd, 0);
        check("to_mreq", mmio_req, 0);
        @(negedge clock);
        data_addr = 16'hF000; data_size = 1'b0; data_write = 1'b0; data_req = 1'b1;
        @(posedge clock);
        repeat (3) @(negedge clock);
        check("pre_rst_mreq", mmio_req, 3'b001);
`else
        @(negedge clock);
        data_addr = 16'hF000; data_size = 1'b0; data_write = 1'b0; data_req = 1'b1;
        @(posedge clock);
        seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (data_done) seen = 1'b1;
        end
        check("wait100_done", seen, 0);
        check("wait100_mreq", mmio_req, 3'b001);
`endif

        // reset in MMIO_WAIT aborts immediately; RAM survives
        reset = 1'b1; data_req = 1'b0;
        #1;
        check("rst_mid_mreq", mmio_req, 0);
        check("rst_mid_done", data_done, 0);
        @(negedge clock);
        reset = 1'b0;
        do_acc(16'h0010, 16'h0000, 1'b1, 1'b0, rd, er, lat);
        check("post_rst_data", rd, 16'hABCD);
        check("post_rst_lat", lat, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
